// File: rtl/lsu_mem_ctrl.sv
// Load/store initiator for a single-ported combinational memory port.
// Optional macro LSU_MISALIGN_CHECK_EN: reject misaligned requests with resp_err.
module lsu_mem_ctrl #(
  parameter int unsigned WAIT_CYCLES = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_wen,
  input  logic [63:0] req_addr,
  input  logic [63:0] req_wdata,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [63:0] resp_rdata,
  output logic        resp_err,
  output logic [63:0] mem_addr,
  output logic        mem_ce,
  output logic        mem_we,
  output logic [63:0] mem_wdata,
  output logic [7:0]  mem_wmask,
  input  logic [63:0] mem_rdata
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_ACCESS,
    S_RESP
  } state_e;

  localparam logic [3:0] CNT_LAST = 4'(WAIT_CYCLES - 1);

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [63:0] addr_q, addr_d;
  logic [63:0] wdata_q, wdata_d;
  logic [1:0]  size_q, size_d;
  logic        wen_q, wen_d;
  logic        uns_q, uns_d;
  logic [63:0] rdata_q, rdata_d;
  logic        err_q, err_d;

  logic [2:0]  lo_mask;
  logic        misaligned;
  logic [63:0] req_addr_eff;
  logic [7:0]  size_mask;
  logic [63:0] rd_shift;
  logic [63:0] rd_ext;

  // Low address bits that must be zero for natural alignment
  always_comb begin
    lo_mask = 3'b000;
    unique case (req_size)
      2'd0: lo_mask = 3'b000;
      2'd1: lo_mask = 3'b001;
      2'd2: lo_mask = 3'b011;
      2'd3: lo_mask = 3'b111;
    endcase
  end

  assign misaligned = |(req_addr[2:0] & lo_mask);

`ifdef LSU_MISALIGN_CHECK_EN
  assign req_addr_eff = req_addr;
`else
  assign req_addr_eff = {req_addr[63:3], req_addr[2:0] & ~lo_mask};
`endif

  always_comb begin
    size_mask = 8'h00;
    unique case (size_q)
      2'd0: size_mask = 8'h01;
      2'd1: size_mask = 8'h03;
      2'd2: size_mask = 8'h0f;
      2'd3: size_mask = 8'hff;
    endcase
  end

  assign rd_shift = mem_rdata >> {addr_q[2:0], 3'b000};

  always_comb begin
    rd_ext = rd_shift;
    unique case (size_q)
      2'd0: rd_ext = uns_q ? {56'd0, rd_shift[7:0]}
                           : {{56{rd_shift[7]}}, rd_shift[7:0]};
      2'd1: rd_ext = uns_q ? {48'd0, rd_shift[15:0]}
                           : {{48{rd_shift[15]}}, rd_shift[15:0]};
      2'd2: rd_ext = uns_q ? {32'd0, rd_shift[31:0]}
                           : {{32{rd_shift[31]}}, rd_shift[31:0]};
      2'd3: rd_ext = rd_shift;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    size_d     = size_q;
    wen_d      = wen_q;
    uns_d      = uns_q;
    rdata_d    = rdata_q;
    err_d      = err_q;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    mem_ce     = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = 64'd0;
    mem_wdata  = 64'd0;
    mem_wmask  = 8'd0;
    unique case (state_q)
      S_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          addr_d  = req_addr_eff;
          wdata_d = req_wdata;
          size_d  = req_size;
          wen_d   = req_wen;
          uns_d   = req_unsigned;
          rdata_d = 64'd0;
          err_d   = 1'b0;
          cnt_d   = 4'd0;
`ifdef LSU_MISALIGN_CHECK_EN
          if (misaligned) begin
            err_d   = 1'b1;
            state_d = S_RESP;
          end else
`endif
          if (WAIT_CYCLES > 0) state_d = S_WAIT;
          else state_d = S_ACCESS;
        end
      end
      S_WAIT: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d   = 4'd0;
          state_d = S_ACCESS;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      S_ACCESS: begin
        mem_ce   = 1'b1;
        mem_we   = wen_q;
        mem_addr = {addr_q[63:3], 3'b000};
        if (wen_q) begin
          mem_wmask = size_mask << addr_q[2:0];
          mem_wdata = wdata_q << {addr_q[2:0], 3'b000};
        end else begin
          rdata_d = rd_ext;
        end
        state_d = S_RESP;
      end
      S_RESP: begin
        resp_valid = 1'b1;
        if (resp_ready) state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      addr_q  <= 64'd0;
      wdata_q <= 64'd0;
      size_q  <= 2'd0;
      wen_q   <= 1'b0;
      uns_q   <= 1'b0;
      rdata_q <= 64'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      size_q  <= size_d;
      wen_q   <= wen_d;
      uns_q   <= uns_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  assign resp_rdata = rdata_q;

`ifdef LSU_MISALIGN_CHECK_EN
  assign resp_err = err_q;
`else
  assign resp_err = 1'b0;
  logic unused_err;
  assign unused_err = err_q ^ misaligned;
`endif

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Randomized bench for lsu_mem_ctrl against a byte-level reference memory.
// Expectations follow LSU_MISALIGN_CHECK_EN when the macro is defined.
module tb_lsu_mem_ctrl;

  localparam int W = 3;
  localparam logic [63:0] BASE = 64'h8000_0000;

  logic        clk = 0;
  logic        rst_n = 0;
  logic        req_valid = 0;
  logic        req_ready;
  logic        req_wen = 0;
  logic [63:0] req_addr = 0;
  logic [63:0] req_wdata = 0;
  logic [1:0]  req_size = 0;
  logic        req_unsigned = 0;
  logic        resp_valid;
  logic        resp_ready = 0;
  logic [63:0] resp_rdata;
  logic        resp_err;
  logic [63:0] mem_addr;
  logic        mem_ce;
  logic        mem_we;
  logic [63:0] mem_wdata;
  logic [7:0]  mem_wmask;
  logic [63:0] mem_rdata = 0;

  int passed = 0;
  int total = 0;

  lsu_mem_ctrl #(.WAIT_CYCLES(W)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_wen(req_wen), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_size(req_size),
    .req_unsigned(req_unsigned),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_err(resp_err),
    .mem_addr(mem_addr), .mem_ce(mem_ce), .mem_we(mem_we),
    .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

`ifdef LSU_MISALIGN_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  // Word-organised memory the DUT talks to
  logic [63:0] mem [logic [60:0]];
  // Independent byte-level reference
  logic [7:0]  ref_b [logic [63:0]];

  always @(mem_addr)
    mem_rdata = mem.exists(mem_addr[63:3]) ? mem[mem_addr[63:3]] : 64'd0;

  always @(posedge clk) begin
    if (mem_ce && mem_we) begin
      logic [63:0] w;
      w = mem.exists(mem_addr[63:3]) ? mem[mem_addr[63:3]] : 64'd0;
      for (int i = 0; i < 8; i++)
        if (mem_wmask[i]) w[8*i +: 8] = mem_wdata[8*i +: 8];
      mem[mem_addr[63:3]] = w;
    end
  end

  int          ce_cnt = 0;
  logic [63:0] acc_addr, acc_wdata;
  logic [7:0]  acc_mask;
  logic        acc_we;

  always @(negedge clk) begin
    if (mem_ce) begin
      ce_cnt++;
      acc_addr  = mem_addr;
      acc_we    = mem_we;
      acc_mask  = mem_wmask;
      acc_wdata = mem_wdata;
    end
  end

  function automatic int nbytes(input logic [1:0] sz);
    return 1 << sz;
  endfunction

  function automatic bit is_mis(input logic [63:0] a, input logic [1:0] sz);
    return (a % nbytes(sz)) != 0;
  endfunction

  function automatic logic [63:0] eff(input logic [63:0] a, input logic [1:0] sz);
    return a - (a % nbytes(sz));
  endfunction

  function automatic logic [63:0] ref_load(input logic [63:0] a,
                                           input logic [1:0] sz,
                                           input logic uns);
    logic [63:0] v;
    int n;
    n = nbytes(sz);
    v = 0;
    for (int i = 0; i < n; i++)
      v = v | (64'(ref_b[eff(a, sz) + 64'(i)]) << (8 * i));
    if (!uns && n < 8 && v[8*n-1])
      v = v | ~((64'd1 << (8 * n)) - 64'd1);
    return v;
  endfunction

  task automatic ref_store(input logic [63:0] a, input logic [1:0] sz,
                           input logic [63:0] d);
    for (int i = 0; i < nbytes(sz); i++)
      ref_b[eff(a, sz) + 64'(i)] = d[8*i +: 8];
  endtask

  task automatic put_word(input logic [63:0] a, input logic [63:0] d);
    mem[a[63:3]] = d;
    for (int i = 0; i < 8; i++) ref_b[a + 64'(i)] = d[8*i +: 8];
  endtask

  task automatic send(input logic wen, input logic [63:0] a,
                      input logic [63:0] wd, input logic [1:0] sz,
                      input logic uns, input int hold,
                      output logic [63:0] rd, output logic er,
                      output int lat, output bit stable);
    @(negedge clk);
    req_valid = 1; req_wen = wen; req_addr = a;
    req_wdata = wd; req_size = sz; req_unsigned = uns;
    resp_ready = 0;
    ce_cnt = 0;
    @(posedge clk);
    #1 req_valid = 0;
    lat = 0;
    stable = 1;
    do begin
      @(negedge clk);
      lat++;
    end while (!resp_valid && lat < 60);
    if (!resp_valid) begin
      total++;
      $display("FAIL resp_timeout got resp_valid=%b need 1", resp_valid);
    end
    rd = resp_rdata;
    er = resp_err;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      if (resp_valid !== 1 || resp_rdata !== rd || req_ready !== 0)
        stable = 0;
    end
    @(negedge clk);
    resp_ready = 1;
    @(posedge clk);
    #1 resp_ready = 0;
  endtask

  task automatic test_reset();
    rst_n = 0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1;
    @(negedge clk);
    total++;
    if (req_ready !== 1) $display("FAIL rst_req_ready got %b need 1", req_ready);
    else passed++;
    total++;
    if ({resp_valid, resp_err, mem_ce, mem_we} !== 4'b0)
      $display("FAIL rst_ctl got %b need 0000", {resp_valid, resp_err, mem_ce, mem_we});
    else passed++;
    total++;
    if ({resp_rdata, mem_addr, mem_wdata, mem_wmask} !== 200'd0)
      $display("FAIL rst_data got %h/%h/%h/%h need 0",
               resp_rdata, mem_addr, mem_wdata, mem_wmask);
    else passed++;
  endtask

  task automatic test_loads();
    logic [63:0] rd, exp;
    logic er;
    int lat;
    bit st;
    send(0, BASE + 7, 0, 2'd0, 0, 0, rd, er, lat, st);
    total++;
    if (rd !== 64'hFFFF_FFFF_FFFF_FF88)
      $display("FAIL lb_signed got %h need ffffffffffffff88", rd);
    else passed++;
    total++;
    if (acc_addr !== BASE || ce_cnt !== 1)
      $display("FAIL lb_access got addr=%h ce=%0d need %h ce=1", acc_addr, ce_cnt, BASE);
    else passed++;
    send(0, BASE + 6, 0, 2'd1, 1, 0, rd, er, lat, st);
    total++;
    if (rd !== 64'h8877) $display("FAIL lhu got %h need 8877", rd);
    else passed++;
    send(0, BASE + 4, 0, 2'd2, 0, 0, rd, er, lat, st);
    exp = 64'hFFFF_FFFF_8877_6655;
    total++;
    if (rd !== exp) $display("FAIL lw_signed got %h need %h", rd, exp);
    else passed++;
  endtask

  task automatic test_store();
    logic [63:0] rd;
    logic er;
    int lat;
    bit st;
    send(1, BASE + 4, 64'hDEAD_BEEF, 2'd2, 0, 0, rd, er, lat, st);
    ref_store(BASE + 4, 2'd2, 64'hDEAD_BEEF);
    total++;
    if (acc_we !== 1 || acc_mask !== 8'hF0)
      $display("FAIL sw_mask got we=%b mask=%h need we=1 mask=f0", acc_we, acc_mask);
    else passed++;
    total++;
    if (acc_wdata !== 64'hDEAD_BEEF_0000_0000)
      $display("FAIL sw_wdata got %h need deadbeef00000000", acc_wdata);
    else passed++;
    total++;
    if (rd !== 0 || ce_cnt !== 1)
      $display("FAIL sw_resp got rdata=%h ce=%0d need 0 ce=1", rd, ce_cnt);
    else passed++;
    send(0, BASE, 0, 2'd3, 0, 0, rd, er, lat, st);
    total++;
    if (rd !== 64'hDEAD_BEEF_4433_2211)
      $display("FAIL ld_after_sw got %h need deadbeef44332211", rd);
    else passed++;
  endtask

  task automatic test_hold();
    logic [63:0] rd;
    logic er;
    int lat;
    bit st;
    send(0, BASE + 2, 0, 2'd1, 0, 4, rd, er, lat, st);
    total++;
    if (lat !== W + 2) $display("FAIL wait_latency got %0d need %0d", lat, W + 2);
    else passed++;
    total++;
    if (st !== 1) $display("FAIL resp_hold got stable=%b need 1", st);
    else passed++;
    total++;
    if (rd !== ref_load(BASE + 2, 2'd1, 0))
      $display("FAIL hold_data got %h need %h", rd, ref_load(BASE + 2, 2'd1, 0));
    else passed++;
    @(negedge clk);
    total++;
    if (resp_valid !== 0 || req_ready !== 1)
      $display("FAIL post_resp got valid=%b ready=%b need 0/1", resp_valid, req_ready);
    else passed++;
  endtask

  task automatic test_misalign();
    logic [63:0] rd, exp;
    logic er;
    int lat;
    bit st;
    send(0, BASE + 4, 0, 2'd3, 0, 0, rd, er, lat, st);
    exp = CHK ? 64'd0 : ref_load(BASE + 4, 2'd3, 0);
    total++;
    if (er !== CHK || rd !== exp)
      $display("FAIL misalign_resp got err=%b rd=%h need err=%b rd=%h", er, rd, CHK, exp);
    else passed++;
    total++;
    if (ce_cnt !== (CHK ? 0 : 1))
      $display("FAIL misalign_ce got %0d need %0d", ce_cnt, CHK ? 0 : 1);
    else passed++;
    if (!CHK) begin
      total++;
      if (acc_addr !== BASE)
        $display("FAIL misalign_addr got %h need %h", acc_addr, BASE);
      else passed++;
    end
  endtask

  task automatic test_reset_mid();
    logic [63:0] rd, exp;
    logic er;
    int lat, seen;
    bit st;
    exp = ref_load(BASE + 16, 2'd3, 0);
    @(negedge clk);
    req_valid = 1; req_wen = 1; req_addr = BASE + 16;
    req_wdata = 64'h0123_4567_89AB_CDEF; req_size = 2'd3;
    ce_cnt = 0;
    @(posedge clk);
    #1 req_valid = 0;
    @(negedge clk);
    rst_n = 0;
    @(posedge clk);
    #1 rst_n = 1;
    seen = 0;
    @(negedge clk);
    total++;
    if ({resp_valid, mem_ce, mem_we, mem_addr, mem_wdata, mem_wmask, resp_rdata} !== 0)
      $display("FAIL midrst_out got v=%b ce=%b addr=%h need all 0", resp_valid, mem_ce, mem_addr);
    else passed++;
    total++;
    if (req_ready !== 1) $display("FAIL midrst_ready got %b need 1", req_ready);
    else passed++;
    repeat (8) begin
      @(negedge clk);
      if (resp_valid) seen++;
    end
    total++;
    if (ce_cnt !== 0 || seen !== 0)
      $display("FAIL midrst_quiet got ce=%0d resp=%0d need 0/0", ce_cnt, seen);
    else passed++;
    send(0, BASE + 16, 0, 2'd3, 0, 0, rd, er, lat, st);
    total++;
    if (rd !== exp) $display("FAIL midrst_mem got %h need %h", rd, exp);
    else passed++;
  endtask

  task automatic test_random();
    logic [63:0] rd, a, wd, exp;
    logic er, wen, uns, skip;
    logic [1:0] sz;
    logic [7:0] m;
    int lat;
    bit st;
    for (int k = 0; k < 40; k++) begin
      wen = 1'($urandom);
      uns = 1'($urandom);
      sz  = 2'($urandom);
      a   = BASE + 64'($urandom_range(0, 63));
      wd  = {$urandom, $urandom};
      skip = CHK && is_mis(a, sz);
      exp = (skip || wen) ? 64'd0 : ref_load(a, sz, uns);
      send(wen, a, wd, sz, uns, 0, rd, er, lat, st);
      if (wen && !skip) ref_store(a, sz, wd);
      total++;
      if (rd !== exp || er !== skip)
        $display("FAIL rand_resp[%0d] got rd=%h err=%b need rd=%h err=%b",
                 k, rd, er, exp, skip);
      else passed++;
      total++;
      if (ce_cnt !== (skip ? 0 : 1) || lat !== (skip ? 1 : W + 2))
        $display("FAIL rand_timing[%0d] got ce=%0d lat=%0d", k, ce_cnt, lat);
      else passed++;
      if (!skip) begin
        m = 8'(((1 << nbytes(sz)) - 1) << (eff(a, sz) % 8));
        total++;
        if (acc_addr !== (a - (a % 8)) || (wen && acc_mask !== m) || acc_we !== wen)
          $display("FAIL rand_access[%0d] got addr=%h mask=%h need addr=%h mask=%h",
                   k, acc_addr, acc_mask, a - (a % 8), m);
        else passed++;
      end
    end
  endtask

  initial begin
    put_word(BASE, 64'h8877_6655_4433_2211);
    for (int w = 1; w < 8; w++)
      put_word(BASE + 64'(8 * w), {$urandom, $urandom});
    test_reset();
    test_loads();
    test_store();
    test_hold();
    test_misalign();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/lsu_mem_ctrl.md
Name: lsu_mem_ctrl

Overview:
- Load/store initiator that drives the single-ported, combinational DPI memory port (addr/ce/we/wdata/wmask in, rdata out).
- Accepts one load/store request at a time from the execute stage over a valid/ready handshake.
- Converts the request into an 8-byte-aligned memory access with byte mask and lane shifting.
- Returns a sign- or zero-extended load result, or a write acknowledge, over a second valid/ready handshake.

Parameters:
- WAIT_CYCLES, 0, idle cycles inserted between request acceptance and the memory access cycle (models memory latency); range 0–15.

Ports:
- clk  in  1  system clock, all state on rising edge
- rst_n  in  1  synchronous active-low reset
- req_valid  in  1  request present
- req_ready  out  1  controller can accept a request
- req_wen  in  1  1 = store, 0 = load
- req_addr  in  64  byte address
- req_wdata  in  64  store data, right-aligned
- req_size  in  2  0 = byte, 1 = half, 2 = word, 3 = double
- req_unsigned  in  1  load zero-extends when 1, sign-extends when 0
- resp_valid  out  1  response present
- resp_ready  in  1  consumer accepts response
- resp_rdata  out  64  extended load data; 0 for stores and errors
- resp_err  out  1  misaligned access
- mem_addr  out  64  aligned address, {req_addr[63:3],3'b000}
- mem_ce  out  1  memory enable
- mem_we  out  1  memory write enable
- mem_wdata  out  64  lane-shifted store data
- mem_wmask  out  8  byte write mask
- mem_rdata  in  64  combinational read data

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-low on rst_n, sampled on the rising edge of clk.
- Reset values: state IDLE, wait counter 0, all registered request fields 0. resp_valid=0, resp_err=0, resp_rdata=0, mem_ce=0, mem_we=0, mem_addr=0, mem_wdata=0, mem_wmask=0. req_ready=1 in the first cycle after reset.
- States: IDLE, WAIT, ACCESS, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid, latch addr/wdata/size/wen/unsigned.
  - Next state: RESP with err if misaligned (feature on); else WAIT if WAIT_CYCLES>0; else ACCESS.
- WAIT: counter counts up to WAIT_CYCLES-1, then goes to ACCESS. mem_ce=0.
- ACCESS:
  - Exactly one cycle.
  - mem_ce=1; mem_we=latched wen.
  - mem_wmask = size mask (0x01/0x03/0x0F/0xFF) << addr[2:0].
  - mem_wdata = wdata << (8*addr[2:0]).
  - For loads, mem_wmask=0 and mem_wdata=0.
  - Loads: capture (mem_rdata >> 8*addr[2:0]), truncated to size and extended, into resp_rdata at the end of the cycle.
  - Next state: RESP.
- RESP:
  - resp_valid=1.
  - Hold resp_rdata and resp_err stable until resp_ready.
  - On resp_ready, go to IDLE and clear resp_valid the next cycle.
- Throughput: req_ready is 0 in every state except IDLE. No new request is accepted in the same cycle a response handshakes. Minimum turnaround is 3 cycles per request (IDLE, ACCESS, RESP).
- mem_ce outside ACCESS is 0. The memory therefore sees exactly one access per request, and a store is never issued twice.
- Misaligned means addr not a multiple of the access size: half with addr[0]!=0; word with addr[1:0]!=0; double with addr[2:0]!=0. Byte accesses are never misaligned.
- Stores: resp_rdata=0 always.
- Reset mid-operation: abort immediately, no response is produced. A store is committed only if its ACCESS cycle completed before reset.
- req_* inputs are ignored outside IDLE.

Optional Feature:
- Macro: LSU_MISALIGN_CHECK_EN.
- Defined: misaligned requests skip WAIT/ACCESS, mem_ce is never asserted, and the response carries resp_err=1 with resp_rdata=0.
- Undefined: resp_err is tied 0, and the address is forced down to natural alignment before access (addr & ~(size_bytes-1)). The access then proceeds normally.

Test Plan:
1. Memory at 0x80000000 holds 0x8877665544332211. Load byte, signed, addr 0x80000007 → resp_rdata=0xFFFFFFFFFFFFFF88; mem_addr=0x80000000; mem_ce high for exactly 1 cycle.
2. Same memory, load half unsigned at 0x80000006 → 0x0000000000008877. Load word signed at 0x80000004 → 0xFFFFFFFF88776655.
3. Store word 0xDEADBEEF at 0x80000004 → in ACCESS: mem_we=1, mem_wmask=0xF0, mem_wdata=0xDEADBEEF00000000. Response has resp_rdata=0. A following double load returns 0xDEADBEEF44332211.
4. WAIT_CYCLES=3, single load: req handshake at cycle N gives mem_ce at cycle N+4 and resp_valid at N+5. Hold resp_ready=0 for 4 cycles: resp_valid and resp_rdata stay stable and req_ready stays 0.
5. With LSU_MISALIGN_CHECK_EN, load double at 0x80000004 → resp_err=1, resp_rdata=0, mem_ce never asserted. Without the macro, the same request reads 0x80000000 with resp_err=0.
6. Assert rst_n=0 during WAIT of a store → mem_ce never asserted, no resp_valid, all outputs zero, req_ready=1 after release.
